chacha_core_p: RTL and testbench

Parametrised ChaCha permutation core, successor to the fixed 20-round, one-round-per-cycle block.
- Configurable round count (ChaCha8/12/20) and rounds unrolled per cycle.
- valid/ready handshakes on input and output; output register holds the result under backpressure.
- Per-transaction HChaCha mode (no feed-forward, 256-bit subkey), used by the XChaCha keystream path feeding the memory-encryption datapath.

---
 rtl/chacha_core_p_pkg.sv | 67 ++++++
 rtl/chacha_core_p_if.sv | 24 ++
 rtl/chacha_core_p_round.sv | 31 +++
 rtl/chacha_core_p.sv | 122 ++++++++++++
 tb/tb_chacha_core_p.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_core_p_pkg.sv
// rtl/chacha_core_p_pkg.sv - ChaCha word/block types, constants, quarter-round and packing helpers
package chacha_core_p_pkg;

  localparam int STATE_W = 512;

  localparam int ROT_1 = 16;
  localparam int ROT_2 = 12;
  localparam int ROT_3 = 8;
  localparam int ROT_4 = 7;

  // "expand 32-byte k"
  localparam logic [31:0] SIGMA_0 = 32'h61707865;
  localparam logic [31:0] SIGMA_1 = 32'h3320646e;
  localparam logic [31:0] SIGMA_2 = 32'h79622d32;
  localparam logic [31:0] SIGMA_3 = 32'h6b206574;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] block_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } quad_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic word_t rotl(input word_t v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic quad_t qr(input quad_t q);
    word_t a, b, c, d;
    a = q.a;
    b = q.b;
    c = q.c;
    d = q.d;
    a = a + b; d = rotl(d ^ a, ROT_1);
    c = c + d; b = rotl(b ^ c, ROT_2);
    a = a + b; d = rotl(d ^ a, ROT_3);
    c = c + d; b = rotl(b ^ c, ROT_4);
    return {a, b, c, d};
  endfunction

  // block_t index i holds state word i, which sits at the top of the flat vector for i=0
  function automatic block_t unpack_state(input logic [STATE_W-1:0] v);
    block_t blk;
    for (int i = 0; i < 16; i++) blk[i] = v[STATE_W-1-32*i -: 32];
    return blk;
  endfunction

  function automatic logic [STATE_W-1:0] pack_state(input block_t blk);
    logic [STATE_W-1:0] v;
    for (int i = 0; i < 16; i++) v[STATE_W-1-32*i -: 32] = blk[i];
    return v;
  endfunction

  function automatic logic [STATE_W-1:0] make_state(input logic [255:0] key, input logic [127:0] tail);
    return {SIGMA_0, SIGMA_1, SIGMA_2, SIGMA_3, key, tail};
  endfunction

endpackage

// File: rtl/chacha_core_p_if.sv
// rtl/chacha_core_p_if.sv - input/output handshake bundle of the ChaCha permutation core
interface chacha_core_p_if;
  import chacha_core_p_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               in_hchacha;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               out_hchacha;

  modport master (
    output in_valid, in_state, in_hchacha, out_ready,
    input  in_ready, out_valid, out_data, out_hchacha
  );

  modport slave (
    input  in_valid, in_state, in_hchacha, out_ready,
    output in_ready, out_valid, out_data, out_hchacha
  );

endinterface

// File: rtl/chacha_core_p_round.sv
// rtl/chacha_core_p_round.sv - one combinational ChaCha round, column or diagonal by parity
module chacha_round
  import chacha_core_p_pkg::*;
(
  input  block_t x,
  input  logic   odd,
  output block_t y
);

  always_comb begin
    quad_t q;
    int    ib, ic, id;
    q  = '0;
    ib = 0;
    ic = 0;
    id = 0;
    y  = x;
    for (int i = 0; i < 4; i++) begin
      // diagonal rounds rotate rows 1..3 left by their row number
      ib = odd ? 4 + ((i + 1) % 4)  : 4 + i;
      ic = odd ? 8 + ((i + 2) % 4)  : 8 + i;
      id = odd ? 12 + ((i + 3) % 4) : 12 + i;
      q  = qr({x[i], x[ib], x[ic], x[id]});
      y[i]  = q.a;
      y[ib] = q.b;
      y[ic] = q.c;
      y[id] = q.d;
    end
  end

endmodule

// File: rtl/chacha_core_p.sv
// rtl/chacha_core_p.sv - ChaCha/HChaCha permutation core, RPC rounds per clock, handshaked in and out
module chacha_core_p
  import chacha_core_p_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int RPC    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  chacha_core_p_if.slave bus,
  output logic           busy
);

  localparam int N   = ROUNDS / RPC;
  localparam int RCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(N - 1);

  if (ROUNDS < 2 || (ROUNDS % 2) != 0 || !(RPC == 1 || RPC == 2 || RPC == 4) || (ROUNDS % RPC) != 0)
  begin : g_bad_params
    $error("chacha_core_p: unsupported ROUNDS=%0d RPC=%0d", ROUNDS, RPC);
  end

  state_t             state;
  block_t             work;
  block_t             orig;
  logic               mode;
  logic [RCW-1:0]     rc;
  block_t             stage [RPC+1];
  logic [RPC-1:0]     odd;
  logic [STATE_W-1:0] result;

  assign stage[0] = work;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    localparam logic JODD = 1'(j % 2);
    // with even RPC every cycle starts on a column round, so only j decides parity
    assign odd[j] = (((RPC % 2) == 1) ? rc[0] : 1'b0) ^ JODD;

    chacha_round u_round (
      .x   (stage[j]),
      .odd (odd[j]),
      .y   (stage[j+1])
    );
  end

  always_comb begin
    block_t f;
    f      = stage[RPC];
    result = '0;
    if (mode) begin
      result[STATE_W-1:STATE_W/2] = {f[0], f[1], f[2], f[3], f[12], f[13], f[14], f[15]};
    end else begin
      for (int i = 0; i < 16; i++) result[STATE_W-1-32*i -: 32] = f[i] + orig[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      bus.in_ready    <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_hchacha <= 1'b0;
      busy            <= 1'b0;
      work            <= '0;
      orig            <= '0;
      mode            <= 1'b0;
      rc              <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            work         <= unpack_state(bus.in_state);
            orig         <= unpack_state(bus.in_state);
            mode         <= bus.in_hchacha;
            rc           <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end

        ST_RUN: begin
          rc <= rc + 1'b1;
          if (rc == RC_LAST) begin
            if (!bus.out_valid || bus.out_ready) begin
              bus.out_data    <= result;
              bus.out_hchacha <= mode;
              bus.out_valid   <= 1'b1;
              bus.in_ready    <= 1'b1;
              busy            <= 1'b0;
              state           <= ST_IDLE;
            end else begin
              // output still occupied: park the finished block in the working regs
              work  <= unpack_state(result);
              state <= ST_HOLD;
            end
          end else begin
            work <= stage[RPC];
          end
        end

        ST_HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_data    <= pack_state(work);
            bus.out_hchacha <= mode;
            bus.out_valid   <= 1'b1;
            bus.in_ready    <= 1'b1;
            busy            <= 1'b0;
            state           <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_core_p.sv
// tb/tb_chacha_core_p.sv - directed-vector bench for chacha_core_p across four parameter sets
module tb_chacha_core_p;
  import chacha_core_p_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   iv   = 4'h0;
  logic [3:0]   ordy = 4'hf;
  logic [511:0] ist  = '0;
  logic         ih   = 1'b0;
  logic [3:0]   irdy, ov, ohc, bsy;
  logic [511:0] od [4];

  chacha_core_p_if b0 ();
  chacha_core_p_if b1 ();
  chacha_core_p_if b2 ();
  chacha_core_p_if b3 ();

  chacha_core_p #(.ROUNDS(20), .RPC(1)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0), .busy(bsy[0]));
  chacha_core_p #(.ROUNDS(20), .RPC(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1), .busy(bsy[1]));
  chacha_core_p #(.ROUNDS(20), .RPC(4)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2), .busy(bsy[2]));
  chacha_core_p #(.ROUNDS(8),  .RPC(4)) d3 (.clk(clk), .rst_n(rst_n), .bus(b3), .busy(bsy[3]));

  assign b0.in_valid = iv[0]; assign b0.in_state = ist; assign b0.in_hchacha = ih; assign b0.out_ready = ordy[0];
  assign b1.in_valid = iv[1]; assign b1.in_state = ist; assign b1.in_hchacha = ih; assign b1.out_ready = ordy[1];
  assign b2.in_valid = iv[2]; assign b2.in_state = ist; assign b2.in_hchacha = ih; assign b2.out_ready = ordy[2];
  assign b3.in_valid = iv[3]; assign b3.in_state = ist; assign b3.in_hchacha = ih; assign b3.out_ready = ordy[3];

  assign irdy[0] = b0.in_ready; assign ov[0] = b0.out_valid; assign ohc[0] = b0.out_hchacha; assign od[0] = b0.out_data;
  assign irdy[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign ohc[1] = b1.out_hchacha; assign od[1] = b1.out_data;
  assign irdy[2] = b2.in_ready; assign ov[2] = b2.out_valid; assign ohc[2] = b2.out_hchacha; assign od[2] = b2.out_data;
  assign irdy[3] = b3.in_ready; assign ov[3] = b3.out_valid; assign ohc[3] = b3.out_hchacha; assign od[3] = b3.out_data;

  block_t qx = '0;
  logic   qodd = 1'b0;
  block_t qy;
  chacha_round u_qr (.x(qx), .odd(qodd), .y(qy));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] qr_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int rounds, input logic hc);
    logic [31:0]  x [16];
    logic [31:0]  o [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      x[i] = s[511-32*i -: 32];
      o[i] = x[i];
    end
    for (int k = 0; k < rounds / 2; k++) begin
      {x[0], x[4], x[8],  x[12]} = qr_ref(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr_ref(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr_ref(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr_ref(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr_ref(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr_ref(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr_ref(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr_ref(x[3], x[4], x[9],  x[14]);
    end
    r = '0;
    if (hc) r[511:256] = {x[0], x[1], x[2], x[3], x[12], x[13], x[14], x[15]};
    else for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + o[i];
    return r;
  endfunction

  // accept on unit u, then count edges until out_valid (bounded)
  task automatic issue(input int u, input logic [511:0] st, input logic hc,
                       output logic [511:0] data, output logic dhc, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!irdy[u] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("unit%0d in_ready wait", u), 32'(w < 50), 1);
    ist = st;
    ih = hc;
    iv[u] = 1'b1;
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = od[u];
    dhc = ohc[u];
  endtask

  typedef struct {
    int           dut;
    logic [511:0] st;
    logic         hc;
    logic [511:0] exp;
    int           lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] rfc_in, rfc_out, hch_in, hch_out, mix_in, got;
    logic         got_hc;
    int           got_lat;
    logic         seen;

    rfc_in = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    rfc_out = {32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
               32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
               32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
               32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
    hch_in = make_state({32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                         32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c},
                        {32'h09000000, 32'h4a000000, 32'h00000000, 32'h27594131});
    hch_out = {32'h423b4182, 32'hfe7bb227, 32'h50420ed3, 32'h737d878a,
               32'hd5e4f9a0, 32'h53a8748a, 32'h13c42ec1, 32'hdcecd326, 256'h0};
    for (int i = 0; i < 16; i++) mix_in[511-32*i -: 32] = 32'(32'h9e3779b9 * (i + 1));

    vt[0] = '{0, rfc_in, 1'b0, rfc_out, 20};
    vt[1] = '{1, rfc_in, 1'b0, rfc_out, 10};
    vt[2] = '{2, rfc_in, 1'b0, rfc_out, 5};
    vt[3] = '{0, hch_in, 1'b1, hch_out, 20};
    vt[4] = '{1, hch_in, 1'b1, hch_out, 10};
    vt[5] = '{3, rfc_in, 1'b0, chacha_ref(rfc_in, 8, 1'b0), 2};
    vt[6] = '{3, hch_in, 1'b1, chacha_ref(hch_in, 8, 1'b1), 2};
    vt[7] = '{2, mix_in, 1'b0, chacha_ref(mix_in, 20, 1'b0), 5};

    // quarter round through a single round stage, column then diagonal placement
    qx = '0; qodd = 1'b0;
    qx[0] = 32'h11111111; qx[4] = 32'h01020304; qx[8] = 32'h9b8d6f43; qx[12] = 32'h01234567;
    #1;
    check("qr column", {qy[0], qy[4], qy[8], qy[12]}, 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb);
    qx = '0; qodd = 1'b1;
    qx[1] = 32'h11111111; qx[6] = 32'h01020304; qx[11] = 32'h9b8d6f43; qx[12] = 32'h01234567;
    #1;
    check("qr diagonal", {qy[1], qy[6], qy[11], qy[12]}, 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb);

    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl", {irdy, ov, ohc, bsy}, 16'h0);
    check("reset data", od[0] | od[1] | od[2] | od[3], '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready before first edge", irdy, 4'h0);
    @(posedge clk);
    #1 check("in_ready after first edge", irdy, 4'hf);

    for (int v = 0; v < 8; v++) begin
      issue(vt[v].dut, vt[v].st, vt[v].hc, got, got_hc, got_lat);
      check($sformatf("vec%0d data", v), got, vt[v].exp);
      check($sformatf("vec%0d hchacha", v), got_hc, vt[v].hc);
      check($sformatf("vec%0d latency", v), got_lat, vt[v].lat);
    end

    // backpressure: two back-to-back blocks on unit 0 with out_ready low
    ordy[0] = 1'b0;
    @(negedge clk);
    check("bp idle ready", irdy[0], 1);
    ist = rfc_in; ih = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    #1;
    ist = hch_in; ih = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("bp first valid", {ov[0], ohc[0]}, 2'b10);
    check("bp first data", od[0], rfc_out);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    check("bp second accepted", {bsy[0], irdy[0], ov[0]}, 3'b101);
    repeat (23) @(posedge clk);
    #1;
    check("bp hold ctrl", {bsy[0], irdy[0], ov[0], ohc[0]}, 4'b1010);
    check("bp hold first stable", od[0], rfc_out);
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    check("bp release ctrl", {bsy[0], irdy[0], ov[0], ohc[0]}, 4'b0111);
    check("bp release data", od[0], hch_out);
    @(posedge clk);
    #1;
    check("bp second stable", {ov[0], od[0]}, {1'b1, hch_out});
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp drained", ov[0], 0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    ist = rfc_in; ih = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset ctrl", {irdy, ov, ohc, bsy}, 16'h0);
    check("mid reset data", od[0] | od[1] | od[2] | od[3], '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ov != 4'h0) seen = 1'b1;
    end
    check("no out_valid after reset", seen, 0);
    issue(0, rfc_in, 1'b0, got, got_hc, got_lat);
    check("post reset data", got, rfc_out);
    check("post reset latency", got_lat, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
